// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment bus decoder.
// Patterns are active-low (bit0=a .. bit6=g), indexed by the hex value they show.
package seg7_pkg;

   localparam int unsigned NUM_DIGITOS = 4;
   localparam int unsigned SEG_W       = 7;
   localparam int unsigned HEX_W       = 4;
   localparam int unsigned NUM_PAT     = 16;

   localparam logic [NUM_PAT-1:0][SEG_W-1:0] PATRONES = {
      ~7'h71, ~7'h79, ~7'h5E, ~7'h39,   // F E d C
      ~7'h7C, ~7'h77, ~7'h6F, ~7'h7F,   // b A 9 8
      ~7'h07, ~7'h7D, ~7'h6D, ~7'h66,   // 7 6 5 4
      ~7'h4F, ~7'h5B, ~7'h06, ~7'h3F    // 3 2 1 0
   };

   localparam logic [SEG_W-1:0] PATRON_BLANCO = 7'h7F;

   typedef enum logic [1:0] {
      ESPERA,
      FILTRO,
      CAPTURADO
   } estado_t;

endpackage

// File: rtl/seg7_patron_a_hex.sv
// Combinational lookup from an active-low segment pattern to its hex value.
module seg7_patron_a_hex
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] patron,
   output logic [HEX_W-1:0] hex_c,
   output logic             valido_c
);

   always_comb begin
      hex_c    = '0;
      valido_c = 1'b0;
      for (int i = 0; i < NUM_PAT; i++) begin
         if (patron == PATRONES[i]) begin
            hex_c    = HEX_W'(i);
            valido_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_decodificador.sv
// Recovers the hex value shown on a multiplexed 4-digit 7-segment bus.
// Optional decimal-point capture is enabled with SEG7_DECODIFICADOR_DP_EN.
module seg7_decodificador
   import seg7_pkg::*;
#(
   parameter int unsigned ESTABLE_CICLOS = 1000
)(
   input  logic                         clock_50mhz,
   input  logic                         reset_n,
   input  logic [SEG_W-1:0]             segmentos,
   input  logic [NUM_DIGITOS-1:0]       anodos,
`ifdef SEG7_DECODIFICADOR_DP_EN
   input  logic                         punto,
   output logic [NUM_DIGITOS-1:0]       puntos,
`endif
   output logic [HEX_W*NUM_DIGITOS-1:0] valor,
   output logic                         valor_valido,
   output logic [NUM_DIGITOS-1:0]       digito_invalido,
   output logic                         error_patron
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned IDX_W = $clog2(NUM_DIGITOS);
   localparam logic [CNT_W-1:0] LIMITE = CNT_W'(ESTABLE_CICLOS - 1);
`ifdef SEG7_DECODIFICADOR_DP_EN
   localparam int unsigned BUS_W = SEG_W + NUM_DIGITOS + 1;
`else
   localparam int unsigned BUS_W = SEG_W + NUM_DIGITOS;
`endif

   logic [BUS_W-1:0]                        bus_c, sync1, sync2, ref_q;
   estado_t                                 estado;
   logic [CNT_W-1:0]                        cnt, cnt_inc_c;
   logic [NUM_DIGITOS-1:0]                  mask, mask_base_c, sel_c;
   logic [NUM_DIGITOS-1:0][HEX_W-1:0]       nib;
   logic [SEG_W-1:0]                        seg_ref_c;
   logic [NUM_DIGITOS-1:0]                  an_ref_c;
   logic [IDX_W-1:0]                        idx_c;
   logic                                    uno_c, cambio_c, captura_c;
   logic [HEX_W-1:0]                        hex_c;
   logic                                    hex_ok_c;
`ifdef SEG7_DECODIFICADOR_DP_EN
   logic [NUM_DIGITOS-1:0]                  pts_nib;

   assign bus_c = {punto, anodos, segmentos};
`else
   assign bus_c = {anodos, segmentos};
`endif

   assign seg_ref_c   = ref_q[SEG_W-1:0];
   assign an_ref_c    = ref_q[SEG_W +: NUM_DIGITOS];
   assign cambio_c    = (sync2 != ref_q);
   assign cnt_inc_c   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   assign captura_c   = (estado == FILTRO) && !cambio_c && (cnt_inc_c == LIMITE);
   assign mask_base_c = (mask == '1) ? '0 : mask;
   assign sel_c       = NUM_DIGITOS'(1) << idx_c;

   // Digit select must have exactly one anode low to be captured.
   always_comb begin
      idx_c = '0;
      uno_c = 1'b0;
      case (an_ref_c)
         4'b1110: begin idx_c = 2'd0; uno_c = 1'b1; end
         4'b1101: begin idx_c = 2'd1; uno_c = 1'b1; end
         4'b1011: begin idx_c = 2'd2; uno_c = 1'b1; end
         4'b0111: begin idx_c = 2'd3; uno_c = 1'b1; end
         default: ;
      endcase
   end

   seg7_patron_a_hex u_patron (
      .patron   (seg_ref_c),
      .hex_c    (hex_c),
      .valido_c (hex_ok_c)
   );

   // ref_q holds the sample under test; a mismatch with sync2 is a bus change.
   always_ff @(posedge clock_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         sync1           <= '1;
         sync2           <= '1;
         ref_q           <= '1;
         estado          <= ESPERA;
         cnt             <= '0;
         mask            <= '0;
         nib             <= '0;
         valor           <= '0;
         valor_valido    <= 1'b0;
         digito_invalido <= '0;
         error_patron    <= 1'b0;
`ifdef SEG7_DECODIFICADOR_DP_EN
         pts_nib         <= '0;
         puntos          <= '0;
`endif
      end else begin
         sync1        <= bus_c;
         sync2        <= sync1;
         error_patron <= 1'b0;
         valor_valido <= (mask == '1);
         mask         <= mask_base_c;
         if (mask == '1) begin
            valor <= nib;
`ifdef SEG7_DECODIFICADOR_DP_EN
            puntos <= pts_nib;
`endif
         end

         case (estado)
            ESPERA: begin
               if (cambio_c) begin
                  estado <= FILTRO;
                  ref_q  <= sync2;
                  cnt    <= '0;
               end
            end
            FILTRO: begin
               if (cambio_c) begin
                  estado <= ESPERA;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_inc_c;
                  if (cnt_inc_c == LIMITE) estado <= CAPTURADO;
               end
            end
            CAPTURADO: begin
               if (cambio_c) begin
                  estado <= FILTRO;
                  ref_q  <= sync2;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_inc_c;
               end
            end
            default: estado <= ESPERA;
         endcase

         // Blank digits and ambiguous selects are ignored entirely.
         if (captura_c && uno_c && (seg_ref_c != PATRON_BLANCO)) begin
            if (hex_ok_c) begin
               nib[idx_c]             <= hex_c;
               mask                   <= mask_base_c | sel_c;
               digito_invalido[idx_c] <= 1'b0;
`ifdef SEG7_DECODIFICADOR_DP_EN
               pts_nib[idx_c]         <= ~ref_q[BUS_W-1];  // 1 = dot lit
`endif
            end else begin
               digito_invalido[idx_c] <= 1'b1;
               error_patron           <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_decodificador.sv
// Self-checking bench for seg7_decodificador with ESTABLE_CICLOS=4.
module tb_seg7_decodificador;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [6:0]  segmentos;
   logic [3:0]  anodos;
   logic [15:0] valor;
   logic        valor_valido;
   logic [3:0]  digito_invalido;
   logic        error_patron;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int errs     = 0;
   logic [15:0] exp_q[$];
   logic [15:0] sb_exp;

   typedef struct {
      logic [3:0][6:0] seg;   // raw active-low bus value per digit
      logic [15:0]     exp;
   } frame_t;
   frame_t frames[3];

   seg7_decodificador #(.ESTABLE_CICLOS(4)) dut (
      .clock_50mhz     (clk),
      .reset_n         (reset_n),
      .segmentos       (segmentos),
      .anodos          (anodos),
      .valor           (valor),
      .valor_valido    (valor_valido),
      .digito_invalido (digito_invalido),
      .error_patron    (error_patron)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [3:0] an_of(input int d);
      logic [3:0] one;
      one = 4'b0001 << d;
      return ~one;
   endfunction

   // Scoreboard: every valor_valido pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (valor_valido === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse: valor=%0h with no frame pending", valor);
            end else begin
               sb_exp = exp_q.pop_front();
               chk("scoreboard_valor", 32'(valor), 32'(sb_exp));
            end
         end
         if (error_patron === 1'b1) errs++;
      end
   end

   // Called on a negedge; returns on a negedge after 'hold' cycles.
   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold,
                        output int lat);
      lat       = 0;
      anodos    = an;
      segmentos = seg;
      for (int k = 1; k <= hold; k++) begin
         @(negedge clk);
         if (valor_valido === 1'b1 && lat == 0) lat = k;
      end
   endtask

   initial begin
      int lat, p0, e0;
      frames[0] = '{seg: {7'h19, 7'h30, 7'h24, 7'h79}, exp: 16'h4321};
      frames[1] = '{seg: {7'h46, 7'h03, 7'h0E, 7'h06}, exp: 16'hCBFE};
      frames[2] = '{seg: {7'h21, 7'h08, 7'h00, 7'h40}, exp: 16'hDA80};

      reset_n   = 1'b0;
      anodos    = 4'hF;
      segmentos = 7'h7F;
      repeat (3) @(negedge clk);
      chk("reset_valor", 32'(valor), 32'h0);
      chk("reset_valido", 32'(valor_valido), 32'h0);
      chk("reset_invalido", 32'(digito_invalido), 32'h0);
      chk("reset_error", 32'(error_patron), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven frames, latency checked on the completing digit
      for (int f = 0; f < 3; f++) begin
         p0 = pulses;
         for (int d = 0; d < 4; d++) begin
            if (d == 3) exp_q.push_back(frames[f].exp);
            drive(an_of(d), frames[f].seg[d], 10, lat);
            if (d == 3) chk("latency", 32'(lat), 32'd7);
         end
         chk("frame_pulses", 32'(pulses - p0), 32'd1);
         chk("frame_valor", 32'(valor), 32'(frames[f].exp));
         chk("frame_invalido", 32'(digito_invalido), 32'h0);
      end

      // Short glitches (invalid and valid) must be filtered out
      p0 = pulses; e0 = errs;
      drive(4'b1110, 7'h06, 10, lat);
      drive(4'b1101, 7'h55, 2, lat);
      drive(4'b1101, 7'h0E, 10, lat);
      drive(4'b1011, 7'h03, 10, lat);
      drive(4'b0111, 7'h79, 2, lat);
      chk("glitch_no_pulse", 32'(pulses - p0), 32'd0);
      exp_q.push_back(16'hCBFE);
      drive(4'b0111, 7'h46, 12, lat);
      chk("glitch_pulses", 32'(pulses - p0), 32'd1);
      chk("glitch_errors", 32'(errs - e0), 32'd0);
      chk("glitch_valor", 32'(valor), 32'hCBFE);

      // Unknown pattern on digit 2, later repaired by a valid 7
      p0 = pulses; e0 = errs;
      drive(4'b1011, 7'h55, 10, lat);
      chk("inv_flag", 32'(digito_invalido), 32'b0100);
      chk("inv_error_pulses", 32'(errs - e0), 32'd1);
      chk("inv_no_pulse", 32'(pulses - p0), 32'd0);
      drive(4'b1110, 7'h12, 10, lat);
      drive(4'b1101, 7'h08, 10, lat);
      drive(4'b0111, 7'h79, 10, lat);
      exp_q.push_back(16'h17A5);
      drive(4'b1011, 7'h78, 10, lat);
      chk("inv_flag_cleared", 32'(digito_invalido), 32'h0);
      chk("inv_digit2", 32'(valor[11:8]), 32'h7);
      chk("inv_pulses", 32'(pulses - p0), 32'd1);

      // Two anodes low, then a blank digit: nothing captured or flagged
      p0 = pulses; e0 = errs;
      drive(4'b1100, 7'h30, 20, lat);
      drive(4'b1110, 7'h7F, 10, lat);
      chk("multi_no_pulse", 32'(pulses - p0), 32'd0);
      chk("multi_no_error", 32'(errs - e0), 32'd0);
      chk("multi_invalido", 32'(digito_invalido), 32'h0);
      chk("multi_valor", 32'(valor), 32'h17A5);

      // Reset mid-frame discards partial digits
      drive(4'b1110, 7'h10, 10, lat);
      drive(4'b1101, 7'h00, 10, lat);
      anodos    = 4'hF;
      segmentos = 7'h7F;
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_valor", 32'(valor), 32'h0);
      chk("midrst_valido", 32'(valor_valido), 32'h0);
      chk("midrst_invalido", 32'(digito_invalido), 32'h0);
      chk("midrst_error", 32'(error_patron), 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      p0 = pulses;
      drive(4'b1011, 7'h78, 10, lat);
      drive(4'b0111, 7'h02, 10, lat);
      chk("postrst_partial", 32'(pulses - p0), 32'd0);
      drive(4'b1110, 7'h10, 10, lat);
      exp_q.push_back(16'h6789);
      drive(4'b1101, 7'h00, 10, lat);
      chk("postrst_pulses", 32'(pulses - p0), 32'd1);
      chk("postrst_valor", 32'(valor), 32'h6789);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_decodificador.md
SEG7_DECODIFICADOR -- requirements
Module: seg7_decodificador

Interface
REQ-001 SHALL have parameter ESTABLE_CICLOS, default 1000, the number of cycles a bus sample must hold before capture (range 2..65535).
REQ-002 SHALL have port clock_50mhz, input, width 1, the single system clock.
REQ-003 SHALL have port reset_n, input, width 1; reset is asynchronous and active-low.
REQ-004 SHALL have port segmentos, input, width 7, active-low segment bus, bit0=a through bit6=g.
REQ-005 SHALL have port anodos, input, width 4, active-low digit select; digit i is enabled when anodos[i]=0.
REQ-006 SHALL have port valor, output, width 16, decoded hex value; digit i maps to valor[4i+3:4i].
REQ-007 SHALL have port valor_valido, output, width 1, a one-cycle pulse when valor updates.
REQ-008 SHALL have port digito_invalido, output, width 4, a per-digit flag that the last capture held an unknown pattern.
REQ-009 SHALL have port error_patron, output, width 1, a one-cycle pulse for each invalid capture.

Function
REQ-010 SHALL pass segmentos and anodos through a 2-flop synchronizer (11 bits) before any use.
REQ-011 SHALL run an FSM with states ESPERA, FILTRO and CAPTURADO:
- ESPERA->FILTRO on any change of the synchronized {anodos,segmentos}.
- FILTRO->ESPERA on a change before the count is reached.
- FILTRO->CAPTURADO when the stability counter reaches ESTABLE_CICLOS-1.
- CAPTURADO->FILTRO on any change.
REQ-012 SHALL clear the stability counter on every sample change; the counter SHALL saturate and never wrap.
REQ-013 SHALL perform exactly one capture per FILTRO->CAPTURADO transition, and only when exactly one anodos bit is 0.
- With zero or several anodos low, SHALL make no capture and raise no flag.
REQ-014 SHALL decode the 16 active-low patterns ~7'h3F,~7'h06,~7'h5B,~7'h4F,~7'h66,~7'h6D,~7'h7D,~7'h07,~7'h7F,~7'h6F,~7'h77,~7'h7C,~7'h39,~7'h5E,~7'h79,~7'h71 to values 0..F in that order.
REQ-015 SHALL ignore the blank pattern 7'h7F: no capture and no flag.
REQ-016 On a valid capture for digit i:
- store the nibble;
- set mask bit i;
- clear digito_invalido[i].
A repeat capture of the same digit before the frame completes SHALL overwrite the nibble.
REQ-017 On an invalid capture for digit i:
- set digito_invalido[i];
- pulse error_patron for 1 cycle;
- leave mask bit i unchanged.
REQ-018 When the mask becomes 4'b1111, the block SHALL:
- load all four nibbles into valor;
- assert valor_valido in the following cycle for exactly 1 cycle;
- clear the mask in that same cycle.
REQ-019 Latency from an input change to valor_valido on the completing digit SHALL be 2 + ESTABLE_CICLOS + 1 cycles.

Reset
REQ-020 While reset_n=0, the block SHALL asynchronously set:
- valor=0, valor_valido=0, digito_invalido=0, error_patron=0;
- mask=0, counter=0, synchronizers=all-ones, FSM=ESPERA.
REQ-021 Reset asserted mid-frame SHALL discard partial nibbles; a complete new frame SHALL be required after release.

Configuration
REQ-022 With macro SEG7_DECODIFICADOR_DP_EN defined:
- the block SHALL add input punto (1, active-low decimal point) and output puntos (4);
- punto SHALL be synchronized with the bus and included in change detection;
- punto SHALL be captured per digit and loaded into puntos together with valor.
REQ-023 Without SEG7_DECODIFICADOR_DP_EN, neither port nor any related logic SHALL exist, and the block SHALL behave per REQ-010..021.

Structure
REQ-024 Package seg7_pkg SHALL hold:
- the 16 pattern constants;
- the blank constant;
- NUM_DIGITOS=4;
- the FSM state typedef.
REQ-025 Pattern lookup SHALL be the combinational sub-module seg7_patron_a_hex (inputs: pattern; outputs: 4-bit value and valid flag).

Verification
All scenarios run with ESTABLE_CICLOS=4.
REQ-026 Digits 0..3 driven with patterns 1,2,3,4 and anodos 1110,1101,1011,0111, each held 10 cycles -> valor=16'h4321, one valor_valido pulse.
REQ-027 Digits 0..3 driven with E,F,b,C -> valor=16'hCBFE; a 2-cycle glitch pattern inserted between digits -> no capture, no error.
REQ-028 segmentos=7'h55 on digit 2 -> digito_invalido=4'b0100, one error_patron pulse, no valor_valido; a later valid 7 on digit 2 completing the frame -> flag clears, valor[11:8]=7.
REQ-029 anodos=4'b1100 with a valid pattern held 20 cycles -> no capture, all outputs unchanged.
REQ-030 reset_n pulsed low after 2 of 4 digits are captured -> all outputs 0; a following full frame of 9,8,7,6 -> valor=16'h6789 with exactly one pulse.
